// File: rtl/instr_fetch_pkg.sv
// Shared constants, state type and pointer helper for the instruction fetch unit.
package instr_fetch_pkg;

  localparam int ADDR_W     = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W      = $clog2(FIFO_DEPTH);

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Circular pointer advance; correct for any depth, not only powers of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/instr_fetch_fifo.sv
// Prefetch buffer: instruction word plus its word address, with occupancy count.
// A pop is legal while full, so a push in the same cycle is accepted then.
module fetch_fifo
  import instr_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic [31:0]       push_data,
  input  logic [ADDR_W-1:0] push_pc,
  input  logic              pop,
  output logic [31:0]       head_data,
  output logic [ADDR_W-1:0] head_pc,
  output logic [CNT_W-1:0]  count
);

  logic [31:0]       data_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] pc_mem   [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic              pop_ok;
  logic              push_ok;

  assign pop_ok  = pop && (count != '0);
  assign push_ok = push && ((count != CNT_W'(FIFO_DEPTH)) || pop_ok);

  assign head_data = data_mem[rd_ptr];
  assign head_pc   = pc_mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush empties the buffer outright.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= next_ptr(wr_ptr);
      if (pop_ok)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  // Entry storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_mem[i] <= '0;
        pc_mem[i]   <= '0;
      end
    end else if (push_ok && !flush) begin
      data_mem[wr_ptr] <= push_data;
      pc_mem[wr_ptr]   <= push_pc;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues sequential program-memory reads into a small
// prefetch buffer, stops on HALT_WORD, and supports redirect with flush.
// Consumer handshake: a head word transfers on a rising edge where
// instr_valid and instr_ready are both high; while instr_valid is high and
// instr_ready low, the presented word holds (only a redirect may remove it).
module instr_fetch
  import instr_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] start_addr,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  output logic        pm_re,
  output logic [31:0] pm_rd_addr,
  input  logic [31:0] pm_data,
  output logic        instr_valid,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic        busy,
  output logic        done,
  output logic [1:0]  state_dbg
);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic              resp_pending;
  logic [ADDR_W-1:0] resp_addr;

  logic [CNT_W-1:0]  fifo_count;
  logic [31:0]       head_data;
  logic [ADDR_W-1:0] head_pc;
  logic [CNT_W:0]    outstanding;
  logic              can_issue;
  logic              redirect_ok;
  logic              start_ok;
  logic              resp_arrive;
  logic              is_halt;
  logic              fifo_push;
  logic              fifo_pop;
  logic              unused_addr_bits;

  // Upper address bits are architecturally ignored.
  assign unused_addr_bits = ^{start_addr[31:ADDR_W], redirect_addr[31:ADDR_W]};

  assign state_dbg   = state;
  assign start_ok    = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign redirect_ok = redirect && ((state == ST_FETCH) || (state == ST_DRAIN));
  assign resp_arrive = resp_pending && (state == ST_FETCH);
  assign is_halt     = (pm_data == HALT_WORD);
  assign fifo_push   = resp_arrive && !is_halt && !redirect_ok;
  assign fifo_pop    = instr_valid && instr_ready;

  // Every issued read reserves a slot until its word leaves the buffer.
  assign outstanding = {1'b0, fifo_count} + (CNT_W+1)'(pm_re) + (CNT_W+1)'(resp_pending);
  assign can_issue   = outstanding < (CNT_W+1)'(FIFO_DEPTH);

  assign instr_valid = (fifo_count != '0);
  assign instr_data  = instr_valid ? head_data : '0;
  assign instr_pc    = instr_valid ? {{(32-ADDR_W){1'b0}}, head_pc} : '0;

  fetch_fifo u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_ok),
    .push      (fifo_push),
    .push_data (pm_data),
    .push_pc   (resp_addr),
    .pop       (fifo_pop),
    .head_data (head_data),
    .head_pc   (head_pc),
    .count     (fifo_count)
  );

  // Fetch control FSM with registered read port and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      pc           <= '0;
      pm_re        <= 1'b0;
      pm_rd_addr   <= '0;
      resp_pending <= 1'b0;
      resp_addr    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      resp_pending <= pm_re;
      resp_addr    <= pm_rd_addr[ADDR_W-1:0];
      case (state)
        ST_IDLE, ST_DONE: begin
          pm_re <= 1'b0;
          if (start_ok) begin
            state      <= ST_FETCH;
            pm_re      <= 1'b1;
            pm_rd_addr <= {{(32-ADDR_W){1'b0}}, start_addr[ADDR_W-1:0]};
            pc         <= start_addr[ADDR_W-1:0] + 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
          end
        end
        ST_FETCH, ST_DRAIN: begin
          if (redirect_ok) begin
            // Kill the read the memory samples now; its response never lands.
            state        <= ST_FETCH;
            pm_re        <= 1'b1;
            pm_rd_addr   <= {{(32-ADDR_W){1'b0}}, redirect_addr[ADDR_W-1:0]};
            pc           <= redirect_addr[ADDR_W-1:0] + 1'b1;
            resp_pending <= 1'b0;
          end else if (state == ST_FETCH) begin
            if (resp_arrive && is_halt) begin
              state        <= ST_DRAIN;
              pm_re        <= 1'b0;
              resp_pending <= 1'b0;
            end else if (can_issue) begin
              pm_re      <= 1'b1;
              pm_rd_addr <= {{(32-ADDR_W){1'b0}}, pc};
              pc         <= pc + 1'b1;
            end else begin
              pm_re <= 1'b0;
            end
          end else begin
            pm_re <= 1'b0;
            if (fifo_count == '0) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: memory model, scoreboard fed by a
// program-walking reference model, directed and randomized scenarios.
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] start_addr = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_addr = '0;
  logic        pm_re;
  logic [31:0] pm_rd_addr;
  logic [31:0] pm_data = '0;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic        busy;
  logic        done;
  logic [1:0]  state_dbg;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .start_addr    (start_addr),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .pm_re         (pm_re),
    .pm_rd_addr    (pm_rd_addr),
    .pm_data       (pm_data),
    .instr_valid   (instr_valid),
    .instr_data    (instr_data),
    .instr_pc      (instr_pc),
    .instr_ready   (instr_ready),
    .busy          (busy),
    .done          (done),
    .state_dbg     (state_dbg)
  );

  // ---------------- memory model ----------------
  logic [31:0] prog [int unsigned];
  int unsigned rd_cnt = 0;

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    if (prog.exists(32'(a))) return prog[32'(a)];
    return {16'h5A5A, a};
  endfunction

  always @(posedge clk) begin
    if (pm_re) begin
      pm_data <= mem_word(pm_rd_addr[15:0]);
      rd_cnt  <= rd_cnt + 1;
    end
  end

  // ---------------- scoreboard / reference model ----------------
  int n_cmp = 0;
  int n_fail = 0;
  logic [63:0] exp_q[$];

  // Program order from a start address up to (not including) the halt word.
  function automatic void build_exp(input logic [15:0] a);
    logic [31:0] w;
    for (int i = 0; i < 64; i++) begin
      w = mem_word(a);
      if (w == HALT_WORD) break;
      exp_q.push_back({16'h0000, a, w});
      a = a + 16'd1;
    end
  endfunction

  task automatic load_basic();
    prog.delete();
    for (int i = 0; i < 4; i++) prog[32'h10 + i] = 32'hA0 + i;
    prog[32'h14] = HALT_WORD;
    for (int i = 0; i < 3; i++) prog[32'h40 + i] = 32'hB0 + i;
    prog[32'h43] = HALT_WORD;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Returns at the first falling edge after start was sampled.
  task automatic pulse_start(input logic [15:0] a);
    @(negedge clk);
    start = 1'b1;
    start_addr = {16'($urandom), a};
    @(negedge clk);
    start = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if (pm_re !== 1'b0) begin n_fail++; $display("FAIL reset_pm_re: got %b want 0", pm_re); end
    n_cmp++; if (pm_rd_addr !== 32'h0) begin n_fail++; $display("FAIL reset_pm_rd_addr: got %h want 0", pm_rd_addr); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    n_cmp++; if ({instr_data, instr_pc} !== 64'h0) begin n_fail++; $display("FAIL reset_head: got %h/%h want 0/0", instr_data, instr_pc); end
    n_cmp++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL reset_status: got busy=%b done=%b want 0/0", busy, done); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if ({pm_re, instr_valid, busy, done} !== 4'b0) begin n_fail++; $display("FAIL idle_quiet: got %b want 0000", {pm_re, instr_valid, busy, done}); end
  endtask

  task automatic test_basic();
    bit finished = 0;
    load_basic();
    exp_q.delete();
    build_exp(16'h0010);
    instr_ready = 1'b1;
    pulse_start(16'h0010);
    n_cmp++; if (!(pm_re && pm_rd_addr == 32'h10 && !instr_valid && busy))
      begin n_fail++; $display("FAIL basic_issue: got re=%b addr=%h valid=%b busy=%b want 1/10/0/1", pm_re, pm_rd_addr, instr_valid, busy); end
    @(negedge clk);
    n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b want 0", instr_valid); end
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (!instr_valid || {instr_pc, instr_data} !== exp_q[0]) begin
        n_fail++;
        $display("FAIL basic_word%0d: got v=%b pc=%h data=%h want pc=%h data=%h", k, instr_valid, instr_pc, instr_data, exp_q[0][63:32], exp_q[0][31:0]);
      end
      void'(exp_q.pop_front());
      @(negedge clk);
    end
    for (int c = 0; c < 10; c++) begin
      if (instr_valid) begin
        n_cmp++; n_fail++;
        $display("FAIL basic_extra_word: got pc=%h data=%h want none", instr_pc, instr_data);
      end
      if (done) begin finished = 1; break; end
      @(negedge clk);
    end
    n_cmp++; if (!finished || busy) begin n_fail++; $display("FAIL basic_done: got done=%b busy=%b want 1/0", done, busy); end
    // Redirect is ignored outside FETCH/DRAIN.
    redirect = 1'b1;
    redirect_addr = 32'h40;
    @(negedge clk);
    redirect = 1'b0;
    @(negedge clk);
    n_cmp++; if (!(done && !pm_re && !busy)) begin n_fail++; $display("FAIL done_ignores_redirect: got done=%b re=%b busy=%b want 1/0/0", done, pm_re, busy); end
  endtask

  task automatic test_backpressure();
    int unsigned r0;
    logic [63:0] held;
    bit finished = 0;
    do_reset();
    load_basic();
    exp_q.delete();
    build_exp(16'h0010);
    instr_ready = 1'b0;
    r0 = rd_cnt;
    pulse_start(16'h0010);
    held = '0;
    for (int c = 0; c < 10; c++) begin
      if (c == 5) begin start = 1'b1; start_addr = 32'h80; end
      if (c == 6) start = 1'b0;
      if (held != '0) begin
        n_cmp++;
        if (!instr_valid || {instr_pc, instr_data} !== held) begin
          n_fail++;
          $display("FAIL stall_hold: got v=%b pc=%h data=%h want %h", instr_valid, instr_pc, instr_data, held);
        end
      end
      if (instr_valid) held = {instr_pc, instr_data};
      @(negedge clk);
    end
    n_cmp++; if (rd_cnt - r0 > 4) begin n_fail++; $display("FAIL stall_reads: got %0d want <=4", rd_cnt - r0); end
    n_cmp++; if (held !== exp_q[0]) begin n_fail++; $display("FAIL stall_head: got %h want %h", held, exp_q[0]); end
    instr_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (instr_valid) begin
        n_cmp++;
        if (exp_q.size() == 0 || {instr_pc, instr_data} !== exp_q[0]) begin
          n_fail++;
          $display("FAIL bp_word: got pc=%h data=%h want %h (left %0d)", instr_pc, instr_data, (exp_q.size() != 0) ? exp_q[0] : 64'h0, exp_q.size());
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (done) begin finished = 1; break; end
      @(negedge clk);
    end
    n_cmp++; if (!finished || exp_q.size() != 0) begin n_fail++; $display("FAIL bp_end: got done=%b left=%0d want 1/0", finished, exp_q.size()); end
  endtask

  // Redirect issued at the edge where the first word is consumed; shared by
  // the plain redirect and the redirect-coincides-with-halt scenarios.
  task automatic run_redirect(input string tag);
    bit finished = 0;
    instr_ready = 1'b1;
    pulse_start(16'h0010);
    @(negedge clk);
    @(negedge clk);
    redirect = 1'b1;
    redirect_addr = {16'hC3C3, 16'h0040};
    n_cmp++;
    if (!instr_valid || {instr_pc, instr_data} !== exp_q[0]) begin
      n_fail++;
      $display("FAIL %s_pre: got v=%b pc=%h data=%h want %h", tag, instr_valid, instr_pc, instr_data, exp_q[0]);
    end
    void'(exp_q.pop_front());
    @(negedge clk);
    redirect = 1'b0;
    n_cmp++; if (!(pm_re && pm_rd_addr == 32'h40 && busy && !done))
      begin n_fail++; $display("FAIL %s_issue: got re=%b addr=%h busy=%b done=%b want 1/40/1/0", tag, pm_re, pm_rd_addr, busy, done); end
    for (int c = 0; c < 40; c++) begin
      if (instr_valid) begin
        n_cmp++;
        if (exp_q.size() == 0 || {instr_pc, instr_data} !== exp_q[0]) begin
          n_fail++;
          $display("FAIL %s_word: got pc=%h data=%h want %h (left %0d)", tag, instr_pc, instr_data, (exp_q.size() != 0) ? exp_q[0] : 64'h0, exp_q.size());
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (done) begin finished = 1; break; end
      @(negedge clk);
    end
    n_cmp++; if (!finished || exp_q.size() != 0) begin n_fail++; $display("FAIL %s_end: got done=%b left=%0d want 1/0", tag, finished, exp_q.size()); end
  endtask

  task automatic test_redirect();
    do_reset();
    load_basic();
    exp_q.delete();
    exp_q.push_back({32'h10, 32'hA0});
    build_exp(16'h0040);
    run_redirect("redir");
  endtask

  task automatic test_redirect_halt();
    do_reset();
    load_basic();
    prog[32'h11] = HALT_WORD;
    exp_q.delete();
    exp_q.push_back({32'h10, 32'hA0});
    build_exp(16'h0040);
    run_redirect("redir_halt");
  endtask

  task automatic test_wrap();
    bit finished = 0;
    do_reset();
    prog.delete();
    prog[32'hFFFE] = 32'd1;
    prog[32'hFFFF] = 32'd2;
    prog[32'h0000] = 32'd3;
    prog[32'h0001] = HALT_WORD;
    exp_q.delete();
    build_exp(16'hFFFE);
    instr_ready = 1'b1;
    pulse_start(16'hFFFE);
    for (int c = 0; c < 30; c++) begin
      n_cmp++; if (pm_rd_addr[31:16] !== 16'h0) begin n_fail++; $display("FAIL wrap_addr_hi: got %h want 0000", pm_rd_addr[31:16]); end
      if (instr_valid) begin
        n_cmp++;
        if (exp_q.size() == 0 || {instr_pc, instr_data} !== exp_q[0]) begin
          n_fail++;
          $display("FAIL wrap_word: got pc=%h data=%h want %h", instr_pc, instr_data, (exp_q.size() != 0) ? exp_q[0] : 64'h0);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (done) begin finished = 1; break; end
      @(negedge clk);
    end
    n_cmp++; if (!finished || exp_q.size() != 0) begin n_fail++; $display("FAIL wrap_end: got done=%b left=%0d want 1/0", finished, exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    load_basic();
    instr_ready = 1'b0;
    pulse_start(16'h0010);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({pm_re, pm_rd_addr, instr_valid, instr_data, instr_pc, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: got re=%b addr=%h v=%b data=%h pc=%h busy=%b done=%b want all 0", pm_re, pm_rd_addr, instr_valid, instr_data, instr_pc, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    instr_ready = 1'b1;
    repeat (6) @(negedge clk);
    n_cmp++; if ({pm_re, instr_valid, busy, done} !== 4'b0) begin n_fail++; $display("FAIL post_reset_idle: got %b want 0000", {pm_re, instr_valid, busy, done}); end
  endtask

  task automatic test_random();
    logic [15:0] base;
    logic [15:0] a;
    logic [31:0] w;
    logic [63:0] held;
    int len;
    bit hold;
    bit finished;
    do_reset();
    for (int it = 0; it < 20; it++) begin
      prog.delete();
      base = 16'($urandom_range(0, 65535));
      len = $urandom_range(1, 10);
      a = base;
      for (int i = 0; i < len; i++) begin
        w = $urandom;
        if (w == HALT_WORD) w = 32'h1234_5678;
        prog[32'(a)] = w;
        a = a + 16'd1;
      end
      prog[32'(a)] = HALT_WORD;
      exp_q.delete();
      build_exp(base);
      pulse_start(base);
      hold = 0;
      held = '0;
      finished = 0;
      for (int c = 0; c < 200; c++) begin
        instr_ready = ($urandom_range(0, 3) != 0);
        if (hold) begin
          n_cmp++;
          if (!instr_valid || {instr_pc, instr_data} !== held) begin
            n_fail++;
            $display("FAIL rnd_hold: got v=%b pc=%h data=%h want %h", instr_valid, instr_pc, instr_data, held);
          end
        end
        if (instr_valid && instr_ready) begin
          n_cmp++;
          if (exp_q.size() == 0 || {instr_pc, instr_data} !== exp_q[0]) begin
            n_fail++;
            $display("FAIL rnd_word: it=%0d got pc=%h data=%h want %h", it, instr_pc, instr_data, (exp_q.size() != 0) ? exp_q[0] : 64'h0);
          end
          if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
        hold = instr_valid && !instr_ready;
        held = {instr_pc, instr_data};
        if (done) begin finished = 1; break; end
        @(negedge clk);
      end
      n_cmp++; if (!finished || exp_q.size() != 0) begin n_fail++; $display("FAIL rnd_end: it=%0d got done=%b left=%0d want 1/0", it, finished, exp_q.size()); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_redirect();
    test_redirect_halt();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of run want finish before 500000");
    $fatal(1, "watchdog expired");
  end

endmodule
